// File: rtl/gaussian_pkg.sv
// Shared constants and state encoding for the 5x5 Gaussian window sequencer.
package gaussian_pkg;

  localparam int KSIZE      = 5;
  localparam int WIN_N      = KSIZE * KSIZE;
  localparam int BORDER     = KSIZE / 2;
  localparam int LB_ROWS    = KSIZE - 1;
  localparam int WIN_CENTER = BORDER * KSIZE + BORDER;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } state_e;

  // Flat index of window element (row r, column c); row 0 is the oldest.
  function automatic int win_idx(input int r, input int c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/gaussian_line_buffer.sv
// Four-row line buffer: reads the stored column at addr_i and cascades rows on write.
module gaussian_line_buffer
  import gaussian_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned IMG_WIDTH = 64,
  localparam int unsigned XW       = $clog2(IMG_WIDTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [XW-1:0]     addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] col_o [LB_ROWS]
);

  // Row 0 holds the most recent line; contents are never reset.
  logic [DWIDTH-1:0] mem_q [LB_ROWS][IMG_WIDTH];

  always_comb begin
    for (int r = 0; r < LB_ROWS; r++) begin
      col_o[r] = mem_q[r][addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[0][addr_i] <= wdata_i;
      for (int r = 1; r < LB_ROWS; r++) begin
        mem_q[r][addr_i] <= mem_q[r-1][addr_i];
      end
    end
  end

endmodule

// File: rtl/gaussian_window_ctrl.sv
// Frame sequencer: streams raster pixels through line buffers into a 5x5 sliding window
// and presents one window per interior pixel over a valid/ready handshake.
module gaussian_window_ctrl
  import gaussian_pkg::*;
#(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 48,
  localparam int unsigned XW        = $clog2(IMG_WIDTH),
  localparam int unsigned YW        = $clog2(IMG_HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic [DWIDTH-1:0] win [WIN_N],
  output logic              win_valid,
  input  logic              win_ready,
  output logic [XW-1:0]     win_x,
  output logic [YW-1:0]     win_y,
  output logic              win_last
);

  state_e            state_q;
  logic [XW-1:0]     col_q;
  logic [YW-1:0]     row_q;
  logic              busy_q, done_q;
  logic              win_valid_q, win_last_q;
  logic [XW-1:0]     win_x_q;
  logic [YW-1:0]     win_y_q;
  logic [DWIDTH-1:0] win_q [WIN_N];

  logic [DWIDTH-1:0] lb_col  [LB_ROWS];
  logic [DWIDTH-1:0] col_vec [KSIZE];
  logic              accept, produce, last_px;

  gaussian_line_buffer #(
    .DWIDTH    (DWIDTH),
    .IMG_WIDTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk_i   (clock),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (in_data),
    .col_o   (lb_col)
  );

  always_comb begin
    in_ready = (state_q == StStream) && (!win_valid_q || win_ready);
    accept   = in_valid && in_ready;
    produce  = (row_q >= YW'(KSIZE - 1)) && (col_q >= XW'(KSIZE - 1));
    last_px  = (row_q == YW'(IMG_HEIGHT - 1)) && (col_q == XW'(IMG_WIDTH - 1));
    // Oldest line first, incoming pixel at the bottom.
    for (int r = 0; r < LB_ROWS; r++) begin
      col_vec[r] = lb_col[LB_ROWS-1-r];
    end
    col_vec[KSIZE-1] = in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && produce) begin
        win_valid_q <= 1'b1;
        win_x_q     <= col_q - XW'(BORDER);
        win_y_q     <= row_q - YW'(BORDER);
        win_last_q  <= last_px;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StStream;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StStream: begin
          if (accept) begin
            if (last_px) begin
              state_q <= StDrain;
            end
            if (col_q == XW'(IMG_WIDTH - 1)) begin
              col_q <= '0;
              row_q <= row_q + YW'(1);
            end else begin
              col_q <= col_q + XW'(1);
            end
          end
        end
        StDrain: begin
          if (!win_valid_q || win_ready) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Window only moves on accept, so it holds steady under backpressure.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
        end
        win_q[win_idx(r, KSIZE - 1)] <= col_vec[r];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign win_last  = win_last_q;
  assign win       = win_q;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Scoreboard bench for gaussian_window_ctrl on an 8x6 frame.
module tb_gaussian_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          win_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          busy, done, in_ready, win_valid, win_last;
  logic [DW-1:0] win [25];
  logic [2:0]    win_x, win_y;

  always #5 clock = ~clock;

  gaussian_window_ctrl #(
    .DWIDTH     (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_x     (win_x),
    .win_y     (win_y),
    .win_last  (win_last)
  );

  typedef struct packed {
    logic [199:0] w;
    logic [7:0]   x;
    logic [7:0]   y;
    logic         last;
    int           acc_cyc;
  } exp_t;

  localparam int KERN [25] = '{2, 4, 5, 4, 2,  4, 9, 12, 9, 4,  5, 12, 15, 12, 5,
                               4, 9, 12, 9, 4,  2, 4, 5, 4, 2};

  exp_t         exp_q [$];
  logic [DW-1:0] frame [W*H];
  int           checks = 0, errors = 0, cyc = 0, done_cnt = 0, win_cnt = 0;
  bit           lat_chk = 0, gauss_chk = 0, rnd_ready = 0, last_sent = 0;
  logic [199:0] first_win, last_win;
  logic [2:0]   first_x, first_y, last_x, last_y;
  logic         last_flag;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [199:0] pack_win();
    logic [199:0] p;
    for (int i = 0; i < 25; i++) p[i*8 +: 8] = win[i];
    return p;
  endfunction

  function automatic int gauss(input logic [199:0] p);
    int s = 0;
    for (int i = 0; i < 25; i++) s += KERN[i] * int'(p[i*8 +: 8]);
    return s / 159;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (done) done_cnt++;
  always @(posedge clock) if (rnd_ready) begin
    #1;
    win_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic check_window();
    exp_t e;
    logic [199:0] got;
    got = pack_win();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_window: got x=%0d y=%0d expected no window", win_x, win_y);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e.w) begin
      errors++;
      $display("FAIL win_data (%0d,%0d): got %h expected %h", e.x, e.y, got, e.w);
    end
    chk("win_x", win_x, e.x);
    chk("win_y", win_y, e.y);
    chk("win_last", win_last, e.last);
    if (lat_chk) chk("win_latency", cyc, e.acc_cyc + 1);
    if (gauss_chk) chk("gauss_out", gauss(got), 100);
    if (win_cnt == 0) begin
      first_win = got; first_x = win_x; first_y = win_y;
    end
    last_win = got; last_x = win_x; last_y = win_y; last_flag = win_last;
    win_cnt++;
  endtask

  always @(negedge clock) if (reset && win_valid && win_ready) check_window();

  task automatic start_frame();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit rnd_valid);
    int r, c;
    bit acc;
    exp_t e;
    last_sent = 0;
    for (int i = 0; i < n; i++) begin
      r = i / W;
      c = i % W;
      acc = 0;
      in_data = frame[i];
      for (int t = 0; t < 200 && !acc; t++) begin
        in_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clock);
        if (in_valid && in_ready) begin
          acc = 1;
          if (r >= 4 && c >= 4) begin
            for (int rr = 0; rr < 5; rr++)
              for (int cc = 0; cc < 5; cc++)
                e.w[(rr*5+cc)*8 +: 8] = frame[(r-4+rr)*W + (c-4+cc)];
            e.x = 8'(c - 2);
            e.y = 8'(r - 2);
            e.last = (r == H-1) && (c == W-1);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
          end
          if (i == n-1) last_sent = 1;
        end
        @(posedge clock); #1;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout: pixel %0d not accepted, required accept", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) begin
      @(posedge clock); #1;
    end
    chk("done_count", done_cnt, target);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < W*H; i++) frame[i] = DW'(i);
  endtask

  task automatic hold_seq();
    logic [199:0] snap;
    logic [2:0]   sx;
    for (int i = 0; i < 200 && !win_valid; i++) @(negedge clock);
    chk("hold_first_window", win_valid, 1);
    @(posedge clock); #1;
    win_ready = 1'b0;
    snap = pack_win();
    sx = win_x;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || win_valid !== 1'b1 || pack_win() !== snap || win_x !== sx) begin
        errors++;
        $display("FAIL hold_frozen: got in_ready=%0b valid=%0b x=%0d expected 0 1 %0d",
                 in_ready, win_valid, win_x, sx);
      end
    end
    @(posedge clock); #1;
    win_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_x", win_x, 0);
    chk("rst_win_y", win_y, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_win_zero", pack_win() == 200'd0, 1);
    @(posedge clock); #1;
    reset = 1'b1;

    // Ramp frame, free-flowing output.
    load_ramp();
    win_cnt = 0; lat_chk = 1;
    start_frame();
    chk("t1_busy", busy, 1);
    send_pixels(W*H, 0);
    wait_done(1);
    lat_chk = 0;
    chk("t1_count", win_cnt, 8);
    chk("t1_first_w0", first_win[0 +: 8], 0);
    chk("t1_first_w12", first_win[12*8 +: 8], 18);
    chk("t1_first_w24", first_win[24*8 +: 8], 36);
    chk("t1_first_x", first_x, 2);
    chk("t1_first_y", first_y, 2);
    chk("t1_last_w24", last_win[24*8 +: 8], 47);
    chk("t1_last_x", last_x, 5);
    chk("t1_last_y", last_y, 3);
    chk("t1_last_flag", last_flag, 1);

    // Backpressure hold after the first window.
    win_cnt = 0;
    start_frame();
    fork
      send_pixels(W*H, 0);
      hold_seq();
    join
    wait_done(2);
    chk("t2_count", win_cnt, 8);

    // Flat frame through the Gaussian kernel.
    for (int i = 0; i < W*H; i++) frame[i] = 8'd100;
    win_cnt = 0; gauss_chk = 1;
    start_frame();
    send_pixels(W*H, 0);
    wait_done(3);
    gauss_chk = 0;
    chk("t3_count", win_cnt, 8);

    // Mid-frame reset abandons the frame.
    load_ramp();
    start_frame();
    send_pixels(20, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_win_valid", win_valid, 0);
    chk("t4_busy", busy, 0);
    repeat (4) @(negedge clock);
    chk("t4_no_done", done_cnt, 3);
    @(posedge clock); #1;
    win_cnt = 0;
    start_frame();
    send_pixels(W*H, 0);
    wait_done(4);
    chk("t4_count", win_cnt, 8);

    // start ignored in STREAM and DRAIN; in_valid ignored in IDLE.
    win_cnt = 0;
    start_frame();
    fork
      send_pixels(W*H, 0);
      begin
        repeat (10) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
      end
      begin
        for (int i = 0; i < 600 && !last_sent; i++) @(posedge clock);
        #1;
        win_ready = 1'b0;
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("t5_drain_busy", busy, 1);
          chk("t5_drain_valid", win_valid, 1);
        end
        @(posedge clock); #1 win_ready = 1'b1;
      end
    join
    wait_done(5);
    chk("t5_count", win_cnt, 8);
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("t5_idle_in_ready", in_ready, 0);
      chk("t5_idle_busy", busy, 0);
    end
    @(posedge clock); #1 in_valid = 1'b0;

    // Random stalls over three back-to-back frames.
    rnd_ready = 1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W*H; i++) frame[i] = DW'($urandom_range(0, 255));
      win_cnt = 0;
      start_frame();
      send_pixels(W*H, 1);
      wait_done(6 + f);
      chk("t6_count", win_cnt, 8);
    end
    rnd_ready = 0;
    @(posedge clock); #1 win_ready = 1'b1;
    repeat (3) @(posedge clock);
    chk("final_done_total", done_cnt, 8);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
